// File: rtl/med_pkg.sv
// Shared definitions for the sliding-window median/vote filter.
// Holds the count-width helper, the vote mode codes and the FSM encoding.
package med_pkg;

  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

  localparam int MODE_MAJ = 0;
  localparam int MODE_THR = 1;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } med_state_t;

endpackage

// File: rtl/median_window_if.sv
// Pixel-side bundle of the median window: stream/control in, vote results out.
// The state and fill fields mirror the internal FSM for checkers.
interface median_window_if
  import med_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 3
);
  // ce and flush are sampled every rising clk edge; there is no back-pressure,
  // the window accepts one sample per edge with ce=1 and results follow that edge.
  logic          ce;
  logic          flush;
  logic [N-1:0]  in;
  logic [CW-1:0] thr;
  logic [CW-1:0] sum;
  logic          med;
  logic          de;
  logic          valid;
  logic [N-1:0]  out;
  logic [N-1:0]  newest;
  logic [CW-1:0] fill;
  med_state_t    state;

  modport master (
    output ce, flush, in, thr,
    input  sum, med, de, valid, out, newest, fill, state
  );

  modport slave (
    input  ce, flush, in, thr,
    output sum, med, de, valid, out, newest, fill, state
  );
endinterface

// File: rtl/med_tap_line.sv
// DEPTH-deep shift line of N-bit samples with clock enable and synchronous clear.
// Exposes the newest (tap 1) and oldest (tap DEPTH) entries.
module med_tap_line #(
  parameter int N     = 4,
  parameter int DEPTH = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         flush,
  input  logic [N-1:0] d,
  output logic [N-1:0] tap1,
  output logic [N-1:0] tap_last
);

  logic [N-1:0] taps [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps <= '{default: '0};
    end else if (flush) begin
      taps <= '{default: '0};
    end else if (ce) begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign tap1     = taps[0];
  assign tap_last = taps[DEPTH-1];

endmodule

// File: rtl/median_window.sv
// Sliding-window binary vote: running mask-bit count, majority/threshold decision,
// window-wide data-enable and fill tracking around a DEPTH-tap sample line.
module median_window
  import med_pkg::*;
#(
  parameter int N        = 4,
  parameter int DEPTH    = 5,
  parameter int MASK_BIT = 3,
  parameter int DE_BIT   = 2,
  parameter int MODE     = MODE_MAJ,
  parameter int CW       = clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  median_window_if.slave  bus
);

  localparam logic [CW-1:0] DEPTH_CW = CW'(DEPTH);
  localparam logic [CW-1:0] MAJ_CW   = CW'((DEPTH + 1) / 2);

  logic [N-1:0]  tap1;
  logic [N-1:0]  tap_last;
  logic [CW-1:0] sum_q;
  logic [CW-1:0] run_q;
  logic [CW-1:0] fill_q;
  logic          med_q;
  logic          de_q;
  logic          valid_q;
  med_state_t    state_q;

  logic [CW-1:0] sum_next;
  logic [CW-1:0] run_next;
  logic [CW-1:0] fill_next;
  logic          vote_next;

  med_tap_line #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_tap_line (
    .clk      (clk),
    .rst      (rst),
    .ce       (bus.ce),
    .flush    (bus.flush),
    .d        (bus.in),
    .tap1     (tap1),
    .tap_last (tap_last)
  );

  // The entering sample is added and the one leaving tap DEPTH removed on the
  // same edge, so the count can never leave 0..DEPTH.
  always_comb begin
    sum_next  = sum_q + CW'(bus.in[MASK_BIT]) - CW'(tap_last[MASK_BIT]);
    run_next  = '0;
    if (bus.in[DE_BIT]) begin
      run_next = (run_q == DEPTH_CW) ? run_q : run_q + 1'b1;
    end
    fill_next = fill_q + 1'b1;
    vote_next = 1'b0;
    if (MODE == MODE_THR) begin
      vote_next = (sum_next >= bus.thr);
    end else begin
      vote_next = (sum_next >= MAJ_CW);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      run_q   <= '0;
      fill_q  <= '0;
      med_q   <= 1'b0;
      de_q    <= 1'b0;
      valid_q <= 1'b0;
      state_q <= ST_FILL;
    end else if (bus.flush) begin
      sum_q   <= '0;
      run_q   <= '0;
      fill_q  <= '0;
      med_q   <= 1'b0;
      de_q    <= 1'b0;
      valid_q <= 1'b0;
      state_q <= ST_FILL;
    end else if (bus.ce) begin
      sum_q <= sum_next;
      run_q <= run_next;
      de_q  <= (run_next == DEPTH_CW);
      med_q <= vote_next;
      case (state_q)
        ST_FILL: begin
          fill_q <= fill_next;
          if (fill_next == DEPTH_CW) begin
            state_q <= ST_RUN;
            valid_q <= 1'b1;
          end
        end
        ST_RUN: begin
          valid_q <= 1'b1;
        end
        default: begin
          state_q <= ST_FILL;
        end
      endcase
    end
  end

  assign bus.sum    = sum_q;
  assign bus.med    = med_q;
  assign bus.de     = de_q;
  assign bus.valid  = valid_q;
  assign bus.out    = tap_last;
  assign bus.newest = tap1;
  assign bus.fill   = fill_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_median_window.sv
// Directed bench for median_window: one majority instance and one threshold
// instance fed the same stream, checked against hand-computed windows.
module tb_median_window;
  import med_pkg::*;

  localparam int N  = 4;
  localparam int CW = 3;

  logic         clk;
  logic         rst;
  logic         ce_v;
  logic         flush_v;
  logic [N-1:0] in_v;
  logic [CW-1:0] thr_v;

  int pass_cnt;
  int total_cnt;

  median_window_if #(.N(N), .CW(CW)) bus0 ();
  median_window_if #(.N(N), .CW(CW)) bus1 ();

  assign bus0.ce    = ce_v;
  assign bus0.flush = flush_v;
  assign bus0.in    = in_v;
  assign bus0.thr   = thr_v;
  assign bus1.ce    = ce_v;
  assign bus1.flush = flush_v;
  assign bus1.in    = in_v;
  assign bus1.thr   = thr_v;

  median_window #(.N(N), .DEPTH(5), .MASK_BIT(3), .DE_BIT(2), .MODE(MODE_MAJ)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  median_window #(.N(N), .DEPTH(5), .MASK_BIT(3), .DE_BIT(2), .MODE(MODE_THR)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // driver: one accepted sample, results sampled 1 time unit after the edge
  task automatic step(input logic [N-1:0] d);
    in_v = d;
    ce_v = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic hold_cycle(input logic [N-1:0] d, input logic [CW-1:0] t);
    in_v  = d;
    thr_v = t;
    ce_v  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [CW-1:0] s, input logic m,
                           input logic e, input logic v, input logic [N-1:0] o);
    check({tag, ".sum"},   32'(bus0.sum),   32'(s));
    check({tag, ".med"},   32'(bus0.med),   32'(m));
    check({tag, ".de"},    32'(bus0.de),    32'(e));
    check({tag, ".valid"}, 32'(bus0.valid), 32'(v));
    check({tag, ".out"},   32'(bus0.out),   32'(o));
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst     = 1'b1;
    ce_v    = 1'b0;
    flush_v = 1'b0;
    in_v    = '0;
    thr_v   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 4'h0);
    check("reset.thr0_med", 32'(bus1.med), 32'd0);
    check("reset.state", 32'(bus0.state), 32'(ST_FILL));
    rst = 1'b0;

    // fill with 4'hC: mask=1, de=1
    step(4'hC);
    check("fill1.thr0_med", 32'(bus1.med), 32'd1);
    check("fill1.sum", 32'(bus0.sum), 32'd1);
    check("fill1.med", 32'(bus0.med), 32'd0);
    step(4'hC);
    step(4'hC);
    check_all("fill3", 3'd3, 1'b1, 1'b0, 1'b0, 4'h0);
    step(4'hC);
    check("fill4.valid", 32'(bus0.valid), 32'd0);
    check("fill4.de", 32'(bus0.de), 32'd0);
    step(4'hC);
    check_all("fill5", 3'd5, 1'b1, 1'b1, 1'b1, 4'hC);
    check("fill5.state", 32'(bus0.state), 32'(ST_RUN));

    // alternating 8/4: steady window sum 3/2
    for (int i = 0; i < 8; i++) begin
      step((i % 2) ? 4'h4 : 4'h8);
      check($sformatf("alt%0d.de", i), 32'(bus0.de), 32'd0);
      if (i >= 4) begin
        check($sformatf("alt%0d.sum", i), 32'(bus0.sum), (i % 2) ? 32'd2 : 32'd3);
        check($sformatf("alt%0d.med", i), 32'(bus0.med), (i % 2) ? 32'd0 : 32'd1);
        check($sformatf("alt%0d.out", i), 32'(bus0.out), (i % 2) ? 32'h4 : 32'h8);
      end
    end

    // data-enable gap
    repeat (5) step(4'hC);
    check_all("degap.pre", 3'd5, 1'b1, 1'b1, 1'b1, 4'hC);
    step(4'h8);
    check("degap.8.de", 32'(bus0.de), 32'd0);
    check("degap.8.sum", 32'(bus0.sum), 32'd5);
    for (int i = 0; i < 5; i++) begin
      step(4'hC);
      check($sformatf("degap%0d.de", i), 32'(bus0.de), (i == 4) ? 32'd1 : 32'd0);
      check($sformatf("degap%0d.sum", i), 32'(bus0.sum), 32'd5);
    end

    // hold: window [0,4,8,C,C] newest first
    step(4'h8);
    step(4'h4);
    step(4'h0);
    check_all("hold.pre", 3'd3, 1'b1, 1'b0, 1'b1, 4'hC);
    hold_cycle(4'hF, 3'd7);
    check_all("hold0", 3'd3, 1'b1, 1'b0, 1'b1, 4'hC);
    check("hold0.thr_med", 32'(bus1.med), 32'd1);
    hold_cycle(4'h0, 3'd0);
    check_all("hold1", 3'd3, 1'b1, 1'b0, 1'b1, 4'hC);
    hold_cycle(4'hF, 3'd7);
    check_all("hold2", 3'd3, 1'b1, 1'b0, 1'b1, 4'hC);
    check("hold2.thr_med", 32'(bus1.med), 32'd1);
    thr_v = 3'd0;
    step(4'h0);
    check_all("resume0", 3'd2, 1'b0, 1'b0, 1'b1, 4'hC);
    step(4'h0);
    check_all("resume1", 3'd1, 1'b0, 1'b0, 1'b1, 4'h8);

    // flush with a concurrent sample
    flush_v = 1'b1;
    step(4'hC);
    flush_v = 1'b0;
    check_all("flush", 3'd0, 1'b0, 1'b0, 1'b0, 4'h0);
    check("flush.state", 32'(bus0.state), 32'(ST_FILL));
    check("flush.newest", 32'(bus0.newest), 32'h0);
    step(4'hC);
    check("refill1.sum", 32'(bus0.sum), 32'd1);
    repeat (3) step(4'hC);
    check("refill4.valid", 32'(bus0.valid), 32'd0);
    check("refill4.sum", 32'(bus0.sum), 32'd4);
    step(4'hC);
    check_all("refill5", 3'd5, 1'b1, 1'b1, 1'b1, 4'hC);

    // reset between edges
    step(4'h8);
    #2;
    rst = 1'b1;
    #1;
    check_all("midrst", 3'd0, 1'b0, 1'b0, 1'b0, 4'h0);
    check("midrst.thr_med", 32'(bus1.med), 32'd0);
    check("midrst.fill", 32'(bus0.fill), 32'd0);
    #1;
    rst = 1'b0;

    // threshold: window holds two mask taps
    thr_v = 3'd2;
    step(4'h8);
    step(4'h8);
    step(4'h0);
    step(4'h0);
    step(4'h0);
    check("thr2.sum", 32'(bus1.sum), 32'd2);
    check("thr2.med", 32'(bus1.med), 32'd1);
    check("thr2.maj_med", 32'(bus0.med), 32'd0);
    check("thr2.valid", 32'(bus1.valid), 32'd1);
    check("thr2.out", 32'(bus1.out), 32'h8);
    thr_v = 3'd3;
    step(4'h8);
    check("thr3.sum", 32'(bus1.sum), 32'd2);
    check("thr3.med", 32'(bus1.med), 32'd0);
    thr_v = 3'd2;
    step(4'h8);
    check("thr2b.med", 32'(bus1.med), 32'd1);
    thr_v = 3'd0;
    for (int i = 0; i < 8; i++) begin
      step(4'h0);
      check($sformatf("thr0_%0d.med", i), 32'(bus1.med), 32'd1);
    end
    check("thr0.sum", 32'(bus1.sum), 32'd0);
    check("thr0.maj_med", 32'(bus0.med), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/median_window.md
# median_window

Parametrised sliding-window binary median/vote filter for the median-filtering pixel path. Keeps the last DEPTH samples of a pixel stream in a tap line, maintains a running count of a selected mask bit, and produces a majority (or programmable-threshold) decision. It also produces a window-wide data-enable, a fill/valid flag and the oldest in-window sample for alignment. It generalises the fixed 5-tap, 4-bit delay/vote stage with:
- configurable width and depth
- threshold mode
- clock enable and flush

## Interface
- N, 4: sample width in bits.
- DEPTH, 5: window length; odd, 3..15.
- MASK_BIT, 3: index of the binary mask bit within a sample.
- DE_BIT, 2: index of the data-enable bit within a sample.
- MODE, 0: 0 = majority (count >= (DEPTH+1)/2); 1 = runtime threshold (count >= thr).
- CW, derived: clog2(DEPTH+1), the count width.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ce  input  1  clock enable; when 0 all state holds.
- flush  input  1  synchronous window clear (frame/line start).
- in  input  N  incoming sample.
- thr  input  CW  vote threshold; used only when MODE=1.
- sum  output  CW  number of taps whose MASK_BIT is 1.
- med  output  1  vote decision.
- de  output  1  1 when DE_BIT is 1 in all DEPTH taps.
- valid  output  1  window holds DEPTH samples accepted since reset/flush.
- out  output  N  oldest in-window sample (tap DEPTH).

## Operation
- **Tap line:** taps 1..DEPTH. On ce=1, tap1 <= in and tap[i] <= tap[i-1].
- **Running count:** sum is maintained incrementally, never by an adder tree.
  - sum' = sum + in[MASK_BIT] - tap[DEPTH][MASK_BIT].
  - Width CW never overflows or underflows.
- **Vote:** med is registered and computed from sum'.
  - MODE=0: med' = (sum' >= (DEPTH+1)/2).
  - MODE=1: med' = (sum' >= thr), using thr sampled at the same edge. thr=0 gives med=1.
- **Data-enable:** run counter run' = in[DE_BIT] ? min(run+1, DEPTH) : 0, with de' = (run' == DEPTH).
- **FSM:** states FILL and RUN; fill counter 0..DEPTH.
  - FILL: each accepted sample increments fill. Moves to RUN when fill reaches DEPTH; valid' = 1 on that edge.
  - RUN: valid stays 1 until flush or reset.
- **flush:** priority over ce. On the edge with flush=1:
  - taps, sum, run, fill, med, de and valid all go to 0; FSM goes to FILL.
  - the concurrent `in` is discarded.
- **ce=0 without flush:** every register holds, thr changes included.
- **Reset values:** asynchronous; all outputs and state are 0 (sum=0, med=0, de=0, valid=0, out=0), FSM in FILL.
  - Exception: MODE=1 with thr=0 shows med=1 only after the first ce edge.
- **Reset mid-stream:** same as reset-time behaviour; no partial window survives.

## Timing
- All outputs are registered and change only on a rising clk edge with ce=1 or flush=1, or on rst.
- A sample accepted at edge k:
  - is included in sum, med and de after edge k (zero extra latency versus the tap line);
  - appears on out after edge k+DEPTH-1;
  - leaves the window at edge k+DEPTH.
- valid rises after the DEPTH-th accepted edge following reset/flush.
- sum, med and de are meaningful but partial while valid=0.
- No combinational path from in to any output.

## Structure
- Shared package med_pkg holds:
  - clog2 constant function;
  - MODE_MAJ=0 and MODE_THR=1 constants;
  - FSM state encoding (ST_FILL, ST_RUN).
- One sub-module, med_tap_line: DEPTH x N shift line with rst, ce and flush, exposing tap1 and tap[DEPTH].
- Count, run, FSM and vote logic live in median_window.

## Test plan
All scenarios use N=4, DEPTH=5, MASK_BIT=3, DE_BIT=2.
1. **Fill:** rst, then 4'hC on 5 ce edges.
   - After edge 3: sum=3, med=1, valid=0, de=0.
   - After edge 5: sum=5, de=1, valid=1, out=4'hC.
2. **Alternating:** steady 4'h8/4'h4 after fill -> sum alternates 3/2, med alternates 1/0, de=0 throughout.
3. **DE gap:** 4'hC stream with a single 4'h8 -> de=0 for exactly 5 edges then 1; sum unchanged (still 5).
4. **Hold:** ce=0 for 3 cycles mid-stream with `in` and thr toggling -> sum, med, de, valid, out bit-identical; resumes exactly on ce=1.
5. **Flush and reset:** flush=1 with ce=1, in=4'hC -> all outputs 0, valid=0, sample not counted; refill needs 5 edges. rst asserted between edges mid-stream -> outputs 0 immediately.
6. **Threshold:** MODE=1, window containing two mask=1 taps.
   - thr=2 -> med=1; thr=3 -> med=0.
   - thr=0 -> med=1 for all windows.
